// File: rtl/fetch_ctrl_if.sv
// Fetch-control bus: ROM data and LUT programming in, PC control and decode hand-off out.
// master is the fetch_ctrl side; slave is the PC/ROM/datapath environment.
interface fetch_ctrl_if #(
    parameter int unsigned addr_w    = 16,
    parameter int unsigned instr_w   = 9,
    parameter int unsigned lut_depth = 16
);
    localparam int unsigned idx_w = $clog2(lut_depth);

    logic               start;
    logic [instr_w-1:0] rom_data;
    logic               acc_nz;
    logic               lut_we;
    logic [idx_w-1:0]   lut_waddr;
    logic [addr_w-1:0]  lut_wdata;
    logic               bnz;
    logic [addr_w-1:0]  jump_here;
    logic               halt;
    logic [instr_w-1:0] instr_out;
    logic               instr_valid;
    logic [15:0]        retired;

    modport master (
        input  start, rom_data, acc_nz, lut_we, lut_waddr, lut_wdata,
        output bnz, jump_here, halt, instr_out, instr_valid, retired
    );

    modport slave (
        output start, rom_data, acc_nz, lut_we, lut_waddr, lut_wdata,
        input  bnz, jump_here, halt, instr_out, instr_valid, retired
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch-stage control: decodes BR/HALT from ROM data, drives PC load/freeze,
// squashes the wrong-path slot and registers the instruction stream for decode.
module fetch_ctrl #(
    parameter int unsigned addr_w    = 16,
    parameter int unsigned instr_w   = 9,
    parameter int unsigned lut_depth = 16
) (
    input logic          clk,
    input logic          reset,
    fetch_ctrl_if.master bus
);
    localparam int unsigned idx_w = $clog2(lut_depth);

    typedef enum logic [1:0] {StIdle, StFlush, StRun, StHalted} state_e;

    state_e             state_q, state_d;
    logic [addr_w-1:0]  lut_q [lut_depth];
    logic [instr_w-1:0] instr_q;
    logic               valid_q;
    logic [15:0]        retired_q;

    logic is_br, is_halt, bnz_c, halt_c, load_valid;

    assign is_br   = (bus.rom_data[instr_w-1 -: 5] == 5'b11110);
    assign is_halt = (bus.rom_data == {instr_w{1'b1}});

    always_comb begin
        state_d    = state_q;
        bnz_c      = 1'b0;
        halt_c     = 1'b1;
        load_valid = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.start) state_d = StFlush;
            end
            StFlush: begin
                halt_c  = 1'b0;
                state_d = StRun;
            end
            StRun: begin
                halt_c     = 1'b0;
                load_valid = 1'b1;
                if (is_halt) begin
                    halt_c  = 1'b1;
                    state_d = StHalted;
                end else if (is_br && bus.acc_nz) begin
                    bnz_c   = 1'b1;
                    state_d = StFlush;
                end
            end
            StHalted: ;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            instr_q   <= '0;
            valid_q   <= 1'b0;
            retired_q <= '0;
            for (int i = 0; i < int'(lut_depth); i++) lut_q[i] <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= load_valid;
            if (load_valid) begin
                instr_q <= bus.rom_data;
                if (retired_q != 16'hFFFF) retired_q <= retired_q + 16'd1;
            end
            // Write lands at the edge, so a same-cycle read still sees the old target.
            if (bus.lut_we) lut_q[bus.lut_waddr] <= bus.lut_wdata;
        end
    end

    assign bus.bnz         = bnz_c;
    assign bus.halt        = halt_c;
    assign bus.jump_here   = lut_q[bus.rom_data[idx_w-1:0]];
    assign bus.instr_out   = instr_q;
    assign bus.instr_valid = valid_q;
    assign bus.retired     = retired_q;
endmodule
